// File: rtl/timer_dev_pkg.sv
// timer_dev_pkg: register offsets, CTRL bit positions, MODE and FSM encodings shared by the timer and MOV
package timer_dev_pkg;
    localparam logic [1:0] OFF_CTRL   = 2'd0;
    localparam logic [1:0] OFF_PRESET = 2'd1;
    localparam logic [1:0] OFF_COUNT  = 2'd2;
    localparam logic [1:0] OFF_RSVD   = 2'd3;
    localparam int CTRL_EN      = 0;
    localparam int CTRL_MODE_LO = 1;
    localparam int CTRL_MODE_HI = 2;
    localparam int CTRL_IM      = 3;
    localparam logic [1:0] MODE_ONESHOT = 2'b00;
    localparam logic [1:0] MODE_AUTO    = 2'b01;
    typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_CNT, ST_INT} state_t;
endpackage

// File: rtl/timer_dev.sv
// timer_dev: memory-mapped countdown timer with one-shot / auto-reload modes and masked irq
// Ports: clk, reset (async active-low), sel/we/addr/wdata bridge write side,
//        rdata combinational read data, irq = CTRL.IM & expiry flag.
module timer_dev
    import timer_dev_pkg::*;
#(
    parameter logic [31:0] RST_PRESET = 32'h0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        sel,
    input  logic        we,
    input  logic [1:0]  addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        irq
);
    logic [3:0]  r_ctrl;
    logic [31:0] r_preset;
    logic [31:0] r_count;
    logic        r_flag;
    state_t      r_state;
    logic        w_wr_ctrl;
    logic        w_wr_preset;
    logic        w_auto;
    logic        w_rearm;

    assign w_wr_ctrl   = sel & we & (addr == OFF_CTRL);
    assign w_wr_preset = sel & we & (addr == OFF_PRESET);
    assign w_auto      = r_ctrl[CTRL_MODE_HI:CTRL_MODE_LO] == MODE_AUTO;
    // The one-shot flag survives plain CTRL edits (e.g. unmasking IM after expiry);
    // it is released by a PRESET write or a CTRL write that re-arms EN.
    assign w_rearm     = w_wr_preset | (w_wr_ctrl & wdata[CTRL_EN]);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ctrl   <= '0;
            r_preset <= RST_PRESET;
        end else begin
            // A software CTRL write takes priority over the one-shot EN clear
            if (w_wr_ctrl)
                r_ctrl <= wdata[3:0];
            else if (r_state == ST_INT && !w_auto)
                r_ctrl[CTRL_EN] <= 1'b0;
            if (w_wr_preset)
                r_preset <= wdata;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            r_count <= '0;
            r_flag  <= 1'b0;
        end else begin
            // Setting wins over any release in the same cycle; auto-reload keeps it to one cycle
            r_flag <= (r_state == ST_INT) ? 1'b1 : (w_auto || w_rearm) ? 1'b0 : r_flag;
            case (r_state)
                ST_IDLE: if (r_ctrl[CTRL_EN]) r_state <= ST_LOAD;
                ST_LOAD: begin
                    r_count <= r_preset;
                    r_state <= ST_CNT;
                end
                ST_CNT: begin
                    // COUNT<=1 (including a PRESET of 0) expires without wrapping
                    if (!r_ctrl[CTRL_EN])
                        r_state <= ST_IDLE;
                    else if (r_count > 32'd1)
                        r_count <= r_count - 32'd1;
                    else begin
                        r_count <= '0;
                        r_state <= ST_INT;
                    end
                end
                ST_INT:  r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        rdata = !sel                ? '0 :
                addr == OFF_CTRL    ? {28'd0, r_ctrl} :
                addr == OFF_PRESET  ? r_preset :
                addr == OFF_COUNT   ? r_count : '0;
    end

    assign irq = r_ctrl[CTRL_IM] & r_flag;
endmodule

// File: tb/tb_timer_dev.sv
// tb_timer_dev: scoreboard-driven bench for timer_dev
module tb_timer_dev;
    import timer_dev_pkg::*;

    localparam logic [31:0] RST_P = 32'h0;

    logic        clk = 1'b0;
    logic        reset;
    logic        sel;
    logic        we;
    logic [1:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        irq;
    int          checks = 0;
    int          failures = 0;

    typedef struct {
        logic [31:0] c;
        logic        i;
    } exp_t;
    exp_t q[$];

    timer_dev #(.RST_PRESET(RST_P)) dut (
        .clk(clk), .reset(reset), .sel(sel), .we(we),
        .addr(addr), .wdata(wdata), .rdata(rdata), .irq(irq)
    );

    always #5 clk = ~clk;

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        sel = 1'b1; we = 1'b1; addr = a; wdata = d;
        @(negedge clk); #1;
        we = 1'b0;
    endtask

    task automatic push(input logic [31:0] c, input logic i);
        exp_t e;
        e.c = c; e.i = i;
        q.push_back(e);
    endtask

    task automatic test_reset;
        repeat (2) @(negedge clk);
        sel = 1'b1;
        for (int a = 0; a < 4; a++) begin
            addr = a[1:0]; #1;
            checks++;
            if (rdata !== 32'd0) begin failures++; $display("FAIL reset_rdata off=%0d: got %h want 0", a, rdata); end
        end
        checks++;
        if (irq !== 1'b0) begin failures++; $display("FAIL reset_irq: got %b want 0", irq); end
        @(negedge clk); reset = 1'b1;
        addr = OFF_PRESET; #1;
        checks++;
        if (rdata !== RST_P) begin failures++; $display("FAIL reset_preset: got %h want %h", rdata, RST_P); end
    endtask

    task automatic test_oneshot;
        exp_t e;
        wr(OFF_PRESET, 32'd5);
        addr = OFF_PRESET; #1;
        checks++;
        if (rdata !== 32'd5) begin failures++; $display("FAIL preset_rd: got %0d want 5", rdata); end
        sel = 1'b0; #1;
        checks++;
        if (rdata !== 32'd0) begin failures++; $display("FAIL unsel_rd: got %h want 0", rdata); end
        wr(OFF_CTRL, 32'h9);
        addr = OFF_COUNT; #1;
        push(0, 0); push(0, 0);
        for (int k = 5; k >= 0; k--) push(k, 0);
        push(0, 1); push(0, 1);
        while (q.size() > 0) begin
            e = q.pop_front();
            checks++;
            if (rdata !== e.c || irq !== e.i) begin failures++; $display("FAIL oneshot_seq: count=%0d irq=%b want count=%0d irq=%b", rdata, irq, e.c, e.i); end
            @(negedge clk); #1;
        end
        addr = OFF_CTRL; #1;
        checks++;
        if (rdata !== 32'h8) begin failures++; $display("FAIL oneshot_en_clr: ctrl=%h want 8", rdata); end
        wr(OFF_CTRL, 32'h0);
        checks++;
        if (irq !== 1'b0) begin failures++; $display("FAIL oneshot_irq_off: got %b want 0", irq); end
    endtask

    task automatic test_autoreload;
        exp_t e;
        int p;
        wr(OFF_PRESET, 32'd3);
        wr(OFF_CTRL, 32'hB);
        addr = OFF_COUNT; #1;
        push(0, 0);
        for (int s = 1; s < 20; s++) begin
            p = (s - 1) % 6;
            push(p == 1 ? 3 : p == 2 ? 2 : p == 3 ? 1 : 0, p == 5);
        end
        while (q.size() > 0) begin
            e = q.pop_front();
            checks++;
            if (rdata !== e.c || irq !== e.i) begin failures++; $display("FAIL auto_seq: count=%0d irq=%b want count=%0d irq=%b", rdata, irq, e.c, e.i); end
            @(negedge clk); #1;
        end
        wr(OFF_CTRL, 32'h0);
        addr = OFF_COUNT; #1;
        for (int s = 0; s < 12; s++) push(2, 0);
        while (q.size() > 0) begin
            e = q.pop_front();
            checks++;
            if (rdata !== e.c || irq !== e.i) begin failures++; $display("FAIL auto_stop: count=%0d irq=%b want count=%0d irq=%b", rdata, irq, e.c, e.i); end
            @(negedge clk); #1;
        end
    endtask

    task automatic test_masked;
        exp_t e;
        wr(OFF_PRESET, 32'd2);
        wr(OFF_CTRL, 32'h1);
        addr = OFF_COUNT; #1;
        push(2, 0); push(2, 0); push(2, 0); push(1, 0);
        for (int s = 0; s < 4; s++) push(0, 0);
        while (q.size() > 0) begin
            e = q.pop_front();
            checks++;
            if (rdata !== e.c || irq !== e.i) begin failures++; $display("FAIL masked_seq: count=%0d irq=%b want count=%0d irq=%b", rdata, irq, e.c, e.i); end
            @(negedge clk); #1;
        end
        addr = OFF_CTRL; #1;
        checks++;
        if (rdata !== 32'h0) begin failures++; $display("FAIL masked_ctrl: got %h want 0", rdata); end
        wr(OFF_CTRL, 32'h8);
        checks++;
        if (irq !== 1'b1) begin failures++; $display("FAIL masked_unmask: irq=%b want 1", irq); end
    endtask

    task automatic test_edges;
        exp_t e;
        wr(OFF_PRESET, 32'd0);
        checks++;
        if (irq !== 1'b0) begin failures++; $display("FAIL preset_wr_release: irq=%b want 0", irq); end
        wr(OFF_CTRL, 32'h9);
        addr = OFF_COUNT; #1;
        for (int s = 0; s < 6; s++) push(0, s >= 4);
        while (q.size() > 0) begin
            e = q.pop_front();
            checks++;
            if (rdata !== e.c || irq !== e.i) begin failures++; $display("FAIL preset0_seq: count=%h irq=%b want count=%h irq=%b", rdata, irq, e.c, e.i); end
            @(negedge clk); #1;
        end
        wr(OFF_COUNT, 32'hFFFF);
        addr = OFF_COUNT; #1;
        checks++;
        if (rdata !== 32'd0) begin failures++; $display("FAIL count_ro: got %h want 0", rdata); end
        wr(OFF_CTRL, 32'hFFFF_FFF8);
        addr = OFF_CTRL; #1;
        checks++;
        if (rdata !== 32'h8) begin failures++; $display("FAIL ctrl_upper: got %h want 8", rdata); end
    endtask

    task automatic test_midop;
        exp_t e;
        wr(OFF_PRESET, 32'd10);
        wr(OFF_CTRL, 32'h1);
        addr = OFF_COUNT; #1;
        push(0, 0); push(0, 0); push(10, 0); push(9, 0);
        while (q.size() > 0) begin
            e = q.pop_front();
            checks++;
            if (rdata !== e.c || irq !== e.i) begin failures++; $display("FAIL midop_run: count=%0d irq=%b want count=%0d irq=%b", rdata, irq, e.c, e.i); end
            @(negedge clk); #1;
        end
        wr(OFF_PRESET, 32'd100);
        addr = OFF_COUNT; #1;
        push(7, 0); push(6, 0);
        while (q.size() > 0) begin
            e = q.pop_front();
            checks++;
            if (rdata !== e.c || irq !== e.i) begin failures++; $display("FAIL midop_preset: count=%0d irq=%b want count=%0d irq=%b", rdata, irq, e.c, e.i); end
            @(negedge clk); #1;
        end
        wr(OFF_CTRL, 32'h0);
        addr = OFF_COUNT; #1;
        for (int s = 0; s < 5; s++) push(4, 0);
        while (q.size() > 0) begin
            e = q.pop_front();
            checks++;
            if (rdata !== e.c || irq !== e.i) begin failures++; $display("FAIL midop_freeze: count=%0d irq=%b want count=%0d irq=%b", rdata, irq, e.c, e.i); end
            @(negedge clk); #1;
        end
        addr = OFF_PRESET; #1;
        checks++;
        if (rdata !== 32'd100) begin failures++; $display("FAIL midop_preset_rd: got %0d want 100", rdata); end
    endtask

    task automatic test_async_reset;
        exp_t e;
        wr(OFF_CTRL, 32'h9);
        addr = OFF_COUNT; #1;
        push(4, 0); push(4, 0); push(100, 0); push(99, 0);
        while (q.size() > 0) begin
            e = q.pop_front();
            checks++;
            if (rdata !== e.c || irq !== e.i) begin failures++; $display("FAIL rst_run: count=%0d irq=%b want count=%0d irq=%b", rdata, irq, e.c, e.i); end
            @(negedge clk); #1;
        end
        #2 reset = 1'b0; #1;
        checks++;
        if (rdata !== 32'd0) begin failures++; $display("FAIL rst_count: got %0d want 0", rdata); end
        addr = OFF_CTRL; #1;
        checks++;
        if (rdata !== 32'd0) begin failures++; $display("FAIL rst_ctrl: got %h want 0", rdata); end
        @(negedge clk); reset = 1'b1; #1;
        wr(OFF_PRESET, 32'd1);
        wr(OFF_CTRL, 32'h9);
        addr = OFF_COUNT; #1;
        push(0, 0); push(0, 0); push(1, 0); push(0, 0); push(0, 1);
        while (q.size() > 0) begin
            e = q.pop_front();
            checks++;
            if (rdata !== e.c || irq !== e.i) begin failures++; $display("FAIL rst_expire: count=%0d irq=%b want count=%0d irq=%b", rdata, irq, e.c, e.i); end
            if (q.size() > 0) begin @(negedge clk); #1; end
        end
        #2 reset = 1'b0; #1;
        checks++;
        if (irq !== 1'b0) begin failures++; $display("FAIL rst_irq_drop: got %b want 0", irq); end
        @(negedge clk); reset = 1'b1; #1;
    endtask

    initial begin
        reset = 1'b0; sel = 1'b0; we = 1'b0; addr = 2'd0; wdata = 32'd0;
        test_reset();
        test_oneshot();
        test_autoreload();
        test_masked();
        test_edges();
        test_midop();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
